// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// Both requesters are normalised into one mem_req_t before issue.
package mem_port_arbiter_pkg;

    localparam int DEF_MAX_DM_STREAK  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_NONE = '{we: 1'b0, addr: 32'h0000_0000,
                                          wdata: 32'h0000_0000, be: 4'h0};

    // Fetches never write: full-word read with no store data.
    function automatic mem_req_t fetch_req(input logic [31:0] addr);
        mem_req_t r;
        r.we    = 1'b0;
        r.addr  = addr;
        r.wdata = 32'h0000_0000;
        r.be    = 4'hF;
        return r;
    endfunction

    function automatic mem_req_t data_req(input logic        we,
                                          input logic [31:0] addr,
                                          input logic [31:0] wdata,
                                          input logic [3:0]  be);
        mem_req_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        r.be    = be;
        return r;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory handshakes around the arbiter.
// slave = arbiter side, master = CPU sequencer plus memory side.
interface mem_port_arbiter_if;

    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic        IF_GNT;
    logic        IF_RVALID;
    logic [31:0] IF_RDATA;

    logic        DM_REQ;
    logic        DM_WE;
    logic [31:0] DM_ADDR;
    logic [31:0] DM_WDATA;
    logic [3:0]  DM_BE;
    logic        DM_GNT;
    logic        DM_RVALID;
    logic [31:0] DM_RDATA;

    logic        RESP_ERR;
    logic        BUSY;

    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_BE;
    logic        MEM_READY;
    logic        MEM_RVALID;
    logic [31:0] MEM_RDATA;

    modport slave (
        input  IF_REQ, IF_ADDR,
        input  DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_BE,
        input  MEM_READY, MEM_RVALID, MEM_RDATA,
        output IF_GNT, IF_RVALID, IF_RDATA,
        output DM_GNT, DM_RVALID, DM_RDATA,
        output RESP_ERR, BUSY,
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE
    );

    modport master (
        output IF_REQ, IF_ADDR,
        output DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_BE,
        output MEM_READY, MEM_RVALID, MEM_RDATA,
        input  IF_GNT, IF_RVALID, IF_RDATA,
        input  DM_GNT, DM_RVALID, DM_RDATA,
        input  RESP_ERR, BUSY,
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE
    );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Owner selection: DM has priority, but after MAX_DM_STREAK consecutive DM
// grants taken while a fetch was waiting, the fetch is forced through.
module arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       gnt_stb,
    output arb_owner_t owner
);

    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    logic [SW-1:0] streak_r;

    // owner for a grant taken this cycle
    always_comb begin
        owner = OWNER_DM;
        if (if_req && (!dm_req || (streak_r == STREAK_MAX))) begin
            owner = OWNER_IF;
        end else begin
            owner = OWNER_DM;
        end
    end

    // streak counts DM wins only while a fetch was kept waiting
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            streak_r <= {SW{1'b0}};
        end else if (gnt_stb) begin
            if ((owner == OWNER_DM) && if_req) begin
                if (streak_r != STREAK_MAX) begin
                    streak_r <= streak_r + SW'(1);
                end
            end else begin
                streak_r <= {SW{1'b0}};
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data access: grant,
// issue, wait for response, return -- one access outstanding at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DM_STREAK  = DEF_MAX_DM_STREAK,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              CLK,
    input  logic              RSTN,
    mem_port_arbiter_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    arb_state_t    state_r;
    arb_owner_t    owner_r;
    arb_owner_t    pick_owner_s;
    mem_req_t      req_r;
    logic [TW-1:0] tmo_r;
    logic          gnt_stb_s;
    logic          if_gnt_r;
    logic          dm_gnt_r;
    logic          if_rvalid_r;
    logic          dm_rvalid_r;
    logic          resp_err_r;
    logic          busy_r;
    logic          mem_req_r;
    logic [31:0]   if_rdata_r;
    logic [31:0]   dm_rdata_r;

    // a new owner is chosen only from IDLE
    always_comb begin
        gnt_stb_s = 1'b0;
        if ((state_r == ARB_IDLE) && (bus.IF_REQ || bus.DM_REQ)) begin
            gnt_stb_s = 1'b1;
        end else begin
            gnt_stb_s = 1'b0;
        end
    end

    arb_pick #(
        .MAX_DM_STREAK (MAX_DM_STREAK)
    ) u_pick (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .if_req  (bus.IF_REQ),
        .dm_req  (bus.DM_REQ),
        .gnt_stb (gnt_stb_s),
        .owner   (pick_owner_s)
    );

    // access sequencer with registered handshake and response outputs
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r     <= ARB_IDLE;
            owner_r     <= OWNER_IF;
            req_r       <= MEM_REQ_NONE;
            tmo_r       <= {TW{1'b0}};
            if_gnt_r    <= 1'b0;
            dm_gnt_r    <= 1'b0;
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;
            resp_err_r  <= 1'b0;
            busy_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            if_rdata_r  <= 32'h0000_0000;
            dm_rdata_r  <= 32'h0000_0000;
        end else begin
            if_gnt_r    <= 1'b0;
            dm_gnt_r    <= 1'b0;
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;
            resp_err_r  <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    if (gnt_stb_s) begin
                        owner_r   <= pick_owner_s;
                        state_r   <= ARB_ISSUE;
                        mem_req_r <= 1'b1;
                        busy_r    <= 1'b1;
                        if (pick_owner_s == OWNER_DM) begin
                            req_r    <= data_req(bus.DM_WE, bus.DM_ADDR, bus.DM_WDATA, bus.DM_BE);
                            dm_gnt_r <= 1'b1;
                        end else begin
                            req_r    <= fetch_req(bus.IF_ADDR);
                            if_gnt_r <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ARB_ISSUE: begin
                    // backpressure may last forever; the timeout only covers WAIT
                    if (bus.MEM_READY) begin
                        state_r   <= ARB_WAIT;
                        mem_req_r <= 1'b0;
                        tmo_r     <= {TW{1'b0}};
                    end else begin
                        mem_req_r <= 1'b1;
                    end
                end
                ARB_WAIT: begin
                    if (bus.MEM_RVALID) begin
                        state_r <= ARB_IDLE;
                        busy_r  <= 1'b0;
                        if (owner_r == OWNER_IF) begin
                            if_rvalid_r <= 1'b1;
                            if_rdata_r  <= bus.MEM_RDATA;
                        end else begin
                            dm_rvalid_r <= 1'b1;
                            if (!req_r.we) begin
                                dm_rdata_r <= bus.MEM_RDATA;
                            end
                        end
                    end else if (tmo_r == TMO_LAST) begin
                        // give up: error response with zeroed data, late data is dropped
                        state_r    <= ARB_IDLE;
                        busy_r     <= 1'b0;
                        resp_err_r <= 1'b1;
                        if (owner_r == OWNER_IF) begin
                            if_rvalid_r <= 1'b1;
                            if_rdata_r  <= 32'h0000_0000;
                        end else begin
                            dm_rvalid_r <= 1'b1;
                            dm_rdata_r  <= 32'h0000_0000;
                        end
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
                end
                default: begin
                    state_r   <= ARB_IDLE;
                    mem_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.IF_GNT    = if_gnt_r;
    assign bus.IF_RVALID = if_rvalid_r;
    assign bus.IF_RDATA  = if_rdata_r;
    assign bus.DM_GNT    = dm_gnt_r;
    assign bus.DM_RVALID = dm_rvalid_r;
    assign bus.DM_RDATA  = dm_rdata_r;
    assign bus.RESP_ERR  = resp_err_r;
    assign bus.BUSY      = busy_r;
    assign bus.MEM_REQ   = mem_req_r;
    assign bus.MEM_WE    = req_r.we;
    assign bus.MEM_ADDR  = req_r.addr;
    assign bus.MEM_WDATA = req_r.wdata;
    assign bus.MEM_BE    = req_r.be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a single-process CPU/memory model
// stepped on the falling edge, with per-scenario inline checks.
module tb_mem_port_arbiter;

    logic CLK;
    logic RSTN;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MAX_DM_STREAK  (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // event logs filled by tick(); owner 0 = IF, 1 = DM
    int          gnt_own_q[$];
    int          gnt_cyc_q[$];
    int          rsp_own_q[$];
    int          rsp_cyc_q[$];
    logic [31:0] rsp_data_q[$];
    logic        rsp_err_q[$];
    logic [31:0] ma_q[$];
    logic [31:0] mwd_q[$];
    logic        mwe_q[$];
    logic [3:0]  mbe_q[$];
    int          memreq_hi;

    // memory model state: response data = m_key ^ accepted address
    int          m_lat = 1;
    int          m_stall_left = 0;
    int          m_cnt = 0;
    bit          m_busy = 1'b0;
    logic [31:0] m_key = 32'h0000_0000;
    logic [31:0] m_resp = 32'h0000_0000;
    bit          if_keep = 1'b0;
    bit          dm_keep = 1'b0;

    function automatic logic [139:0] outs();
        return {bus.IF_GNT, bus.IF_RVALID, bus.IF_RDATA, bus.DM_GNT, bus.DM_RVALID,
                bus.DM_RDATA, bus.RESP_ERR, bus.BUSY, bus.MEM_REQ, bus.MEM_WE,
                bus.MEM_ADDR, bus.MEM_WDATA, bus.MEM_BE};
    endfunction

    task automatic tick();
        @(negedge CLK);
        if (bus.IF_GNT === 1'b1) begin
            gnt_own_q.push_back(0);
            gnt_cyc_q.push_back(cyc);
            if (!if_keep) bus.IF_REQ = 1'b0;
        end
        if (bus.DM_GNT === 1'b1) begin
            gnt_own_q.push_back(1);
            gnt_cyc_q.push_back(cyc);
            if (!dm_keep) bus.DM_REQ = 1'b0;
        end
        if (bus.IF_RVALID === 1'b1) begin
            rsp_own_q.push_back(0);
            rsp_cyc_q.push_back(cyc);
            rsp_data_q.push_back(bus.IF_RDATA);
            rsp_err_q.push_back(bus.RESP_ERR);
        end
        if (bus.DM_RVALID === 1'b1) begin
            rsp_own_q.push_back(1);
            rsp_cyc_q.push_back(cyc);
            rsp_data_q.push_back(bus.DM_RDATA);
            rsp_err_q.push_back(bus.RESP_ERR);
        end
        if (bus.MEM_REQ === 1'b1) memreq_hi++;
        bus.MEM_RVALID = 1'b0;
        if (m_busy) begin
            m_cnt++;
            if (m_cnt == m_lat) begin
                bus.MEM_RVALID = 1'b1;
                bus.MEM_RDATA  = m_resp;
                m_busy = 1'b0;
            end
        end
        bus.MEM_READY = 1'b0;
        if ((bus.MEM_REQ === 1'b1) && !m_busy) begin
            if (m_stall_left > 0) begin
                m_stall_left--;
            end else begin
                bus.MEM_READY = 1'b1;
                m_busy = 1'b1;
                m_cnt  = 0;
                m_resp = m_key ^ bus.MEM_ADDR;
                ma_q.push_back(bus.MEM_ADDR);
                mwd_q.push_back(bus.MEM_WDATA);
                mwe_q.push_back(bus.MEM_WE);
                mbe_q.push_back(bus.MEM_BE);
            end
        end
    endtask

    task automatic clear_logs();
        gnt_own_q.delete(); gnt_cyc_q.delete();
        rsp_own_q.delete(); rsp_cyc_q.delete(); rsp_data_q.delete(); rsp_err_q.delete();
        ma_q.delete(); mwd_q.delete(); mwe_q.delete(); mbe_q.delete();
        memreq_hi = 0;
    endtask

    task automatic wait_rsp(input int n, input int limit);
        int k = 0;
        while ((rsp_own_q.size() < n) && (k < limit)) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        bus.IF_REQ = 1'b0; bus.IF_ADDR = 32'h0;
        bus.DM_REQ = 1'b0; bus.DM_WE = 1'b0; bus.DM_ADDR = 32'h0;
        bus.DM_WDATA = 32'h0; bus.DM_BE = 4'h0;
        bus.MEM_READY = 1'b0; bus.MEM_RVALID = 1'b0; bus.MEM_RDATA = 32'h0;
        clear_logs();
        repeat (3) tick();
        n_run++;
        if (outs() !== {140{1'b0}}) begin
            n_fail++; $display("FAIL reset_outs: got %h, expected all zero", outs());
        end
        RSTN = 1'b1;
        repeat (2) tick();
        n_run++;
        if (outs() !== {140{1'b0}}) begin
            n_fail++; $display("FAIL reset_idle: got %h, expected all zero", outs());
        end
    endtask

    task automatic test_single_fetch();
        int c0;
        clear_logs();
        m_key = 32'hDEAD_BEFF; m_lat = 2;
        c0 = cyc;
        bus.IF_ADDR = 32'h0000_0010; bus.IF_REQ = 1'b1;
        wait_rsp(1, 40);
        tick();
        n_run++;
        if (gnt_own_q.size() !== 1 || gnt_own_q[0] !== 0 || gnt_cyc_q[0] !== c0 + 1) begin
            n_fail++; $display("FAIL single_gnt: got n=%0d cyc=%0d, expected n=1 IF cyc=%0d",
                               gnt_own_q.size(), gnt_cyc_q[0], c0 + 1);
        end
        n_run++;
        if (rsp_own_q.size() !== 1 || rsp_own_q[0] !== 0 || rsp_cyc_q[0] !== c0 + 4) begin
            n_fail++; $display("FAIL single_rsp: got n=%0d cyc=%0d, expected n=1 IF cyc=%0d",
                               rsp_own_q.size(), rsp_cyc_q[0], c0 + 4);
        end
        n_run++;
        if (rsp_data_q[0] !== 32'hDEAD_BEEF || rsp_err_q[0] !== 1'b0) begin
            n_fail++; $display("FAIL single_data: got %h err=%b, expected deadbeef err=0",
                               rsp_data_q[0], rsp_err_q[0]);
        end
        n_run++;
        if (ma_q[0] !== 32'h10 || mwe_q[0] !== 1'b0 || mbe_q[0] !== 4'hF) begin
            n_fail++; $display("FAIL single_mem: got addr=%h we=%b be=%h, expected 10/0/f",
                               ma_q[0], mwe_q[0], mbe_q[0]);
        end
        n_run++;
        if (bus.BUSY !== 1'b0 || bus.IF_RDATA !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL single_after: got busy=%b rdata=%h, expected 0/deadbeef",
                               bus.BUSY, bus.IF_RDATA);
        end
    endtask

    task automatic test_simultaneous();
        int c0;
        clear_logs();
        m_key = 32'h1111_0000; m_lat = 1;
        c0 = cyc;
        bus.IF_ADDR = 32'h0000_0040; bus.IF_REQ = 1'b1;
        bus.DM_WE = 1'b0; bus.DM_ADDR = 32'h0000_0200; bus.DM_BE = 4'hF; bus.DM_REQ = 1'b1;
        wait_rsp(2, 40);
        n_run++;
        if (gnt_own_q.size() !== 2 || gnt_own_q[0] !== 1 || gnt_own_q[1] !== 0 ||
            gnt_cyc_q[0] !== c0 + 1 || gnt_cyc_q[1] !== c0 + 4) begin
            n_fail++; $display("FAIL simul_gnt: got %0d@%0d %0d@%0d, expected DM@%0d IF@%0d",
                               gnt_own_q[0], gnt_cyc_q[0], gnt_own_q[1], gnt_cyc_q[1], c0 + 1, c0 + 4);
        end
        n_run++;
        if (ma_q.size() !== 2 || ma_q[0] !== 32'h200 || ma_q[1] !== 32'h40) begin
            n_fail++; $display("FAIL simul_addr: got %h then %h, expected 200 then 40", ma_q[0], ma_q[1]);
        end
        n_run++;
        if (rsp_own_q[0] !== 1 || rsp_data_q[0] !== 32'h1111_0200 || rsp_cyc_q[0] !== c0 + 3) begin
            n_fail++; $display("FAIL simul_dm_rsp: got own=%0d data=%h cyc=%0d, expected DM 11110200 cyc=%0d",
                               rsp_own_q[0], rsp_data_q[0], rsp_cyc_q[0], c0 + 3);
        end
        n_run++;
        if (rsp_own_q[1] !== 0 || rsp_data_q[1] !== 32'h1111_0040 || rsp_cyc_q[1] !== c0 + 6) begin
            n_fail++; $display("FAIL simul_if_rsp: got own=%0d data=%h cyc=%0d, expected IF 11110040 cyc=%0d",
                               rsp_own_q[1], rsp_data_q[1], rsp_cyc_q[1], c0 + 6);
        end
        tick();
    endtask

    task automatic test_starvation();
        int k = 0;
        clear_logs();
        m_key = 32'h2222_0000; m_lat = 1;
        bus.IF_ADDR = 32'h0000_0048; bus.IF_REQ = 1'b1;
        bus.DM_WE = 1'b0; bus.DM_ADDR = 32'h0000_0300; bus.DM_BE = 4'hF;
        dm_keep = 1'b1; bus.DM_REQ = 1'b1;
        while ((gnt_own_q.size() < 6) && (k < 100)) begin
            tick();
            k++;
        end
        dm_keep = 1'b0; bus.DM_REQ = 1'b0;
        wait_rsp(6, 40);
        tick();
        n_run++;
        if (gnt_own_q.size() !== 6) begin
            n_fail++; $display("FAIL starve_count: got %0d grants, expected 6", gnt_own_q.size());
        end
        n_run++;
        if ({gnt_own_q[0][0], gnt_own_q[1][0], gnt_own_q[2][0], gnt_own_q[3][0],
             gnt_own_q[4][0], gnt_own_q[5][0]} !== 6'b111101) begin
            n_fail++; $display("FAIL starve_order: got %b%b%b%b%b%b, expected 111101 (1=DM)",
                               gnt_own_q[0][0], gnt_own_q[1][0], gnt_own_q[2][0],
                               gnt_own_q[3][0], gnt_own_q[4][0], gnt_own_q[5][0]);
        end
        n_run++;
        if (gnt_cyc_q[4] - gnt_cyc_q[0] !== 12) begin
            n_fail++; $display("FAIL starve_spacing: got %0d cycles to IF grant, expected 12",
                               gnt_cyc_q[4] - gnt_cyc_q[0]);
        end
        n_run++;
        if (rsp_own_q[4] !== 0 || rsp_data_q[4] !== 32'h2222_0048 || bus.DM_RDATA !== 32'h2222_0300) begin
            n_fail++; $display("FAIL starve_data: got own=%0d data=%h dm_rdata=%h, expected IF 22220048 / 22220300",
                               rsp_own_q[4], rsp_data_q[4], bus.DM_RDATA);
        end
    endtask

    task automatic test_store_ack();
        int c0;
        clear_logs();
        m_key = 32'h3333_0000; m_lat = 3;
        c0 = cyc;
        bus.DM_WE = 1'b1; bus.DM_ADDR = 32'h0000_01FC; bus.DM_WDATA = 32'h0000_0005;
        bus.DM_BE = 4'hF; bus.DM_REQ = 1'b1;
        wait_rsp(1, 40);
        tick();
        bus.DM_WE = 1'b0;
        n_run++;
        if (mwe_q.size() !== 1 || mwe_q[0] !== 1'b1 || ma_q[0] !== 32'h1FC ||
            mwd_q[0] !== 32'h5 || mbe_q[0] !== 4'hF) begin
            n_fail++; $display("FAIL store_mem: got we=%b addr=%h wdata=%h be=%h, expected 1/1fc/5/f",
                               mwe_q[0], ma_q[0], mwd_q[0], mbe_q[0]);
        end
        n_run++;
        if (rsp_own_q.size() !== 1 || rsp_own_q[0] !== 1 || rsp_cyc_q[0] !== c0 + 5 || rsp_err_q[0] !== 1'b0) begin
            n_fail++; $display("FAIL store_ack: got n=%0d own=%0d cyc=%0d err=%b, expected DM cyc=%0d err=0",
                               rsp_own_q.size(), rsp_own_q[0], rsp_cyc_q[0], rsp_err_q[0], c0 + 5);
        end
        n_run++;
        if (rsp_data_q[0] !== 32'h2222_0300 || bus.DM_RDATA !== 32'h2222_0300) begin
            n_fail++; $display("FAIL store_rdata: got %h/%h, expected unchanged 22220300",
                               rsp_data_q[0], bus.DM_RDATA);
        end
    endtask

    task automatic test_backpressure_timeout();
        int c0;
        clear_logs();
        m_key = 32'h4444_0000; m_lat = 20; m_stall_left = 10;
        c0 = cyc;
        bus.IF_ADDR = 32'h0000_0080; bus.IF_REQ = 1'b1;
        repeat (12) tick();
        n_run++;
        if (memreq_hi !== 11 || rsp_own_q.size() !== 0 || ma_q.size() !== 1) begin
            n_fail++; $display("FAIL bp_hold: got memreq_cycles=%0d rsp=%0d accepts=%0d, expected 11/0/1",
                               memreq_hi, rsp_own_q.size(), ma_q.size());
        end
        wait_rsp(1, 40);
        repeat (20) tick();
        n_run++;
        if (rsp_own_q.size() !== 1 || rsp_own_q[0] !== 0 || rsp_cyc_q[0] !== c0 + 28) begin
            n_fail++; $display("FAIL tmo_when: got n=%0d own=%0d cyc=%0d, expected one IF rsp cyc=%0d",
                               rsp_own_q.size(), rsp_own_q[0], rsp_cyc_q[0], c0 + 28);
        end
        n_run++;
        if (rsp_err_q[0] !== 1'b1 || rsp_data_q[0] !== 32'h0 || bus.IF_RDATA !== 32'h0) begin
            n_fail++; $display("FAIL tmo_err: got err=%b data=%h hold=%h, expected 1/0/0",
                               rsp_err_q[0], rsp_data_q[0], bus.IF_RDATA);
        end
        n_run++;
        if (m_busy !== 1'b0 || bus.BUSY !== 1'b0) begin
            n_fail++; $display("FAIL tmo_late: got model_busy=%b dut_busy=%b, expected 0/0", m_busy, bus.BUSY);
        end
    endtask

    task automatic test_reset_in_wait();
        int c1;
        clear_logs();
        m_key = 32'h5555_0000; m_lat = 10;
        bus.DM_WE = 1'b0; bus.DM_ADDR = 32'h0000_0044; bus.DM_BE = 4'hF; bus.DM_REQ = 1'b1;
        repeat (5) tick();
        n_run++;
        if (bus.BUSY !== 1'b1 || bus.MEM_ADDR !== 32'h44) begin
            n_fail++; $display("FAIL rstw_pre: got busy=%b addr=%h, expected 1/44", bus.BUSY, bus.MEM_ADDR);
        end
        RSTN = 1'b0;
        #1;
        n_run++;
        if (outs() !== {140{1'b0}}) begin
            n_fail++; $display("FAIL rstw_outs: got %h, expected all zero", outs());
        end
        m_busy = 1'b0; bus.MEM_RVALID = 1'b0; bus.MEM_READY = 1'b0; bus.DM_REQ = 1'b0;
        clear_logs();
        repeat (3) tick();
        RSTN = 1'b1;
        repeat (15) tick();
        n_run++;
        if (rsp_own_q.size() !== 0 || gnt_own_q.size() !== 0) begin
            n_fail++; $display("FAIL rstw_dropped: got rsp=%0d gnt=%0d, expected 0/0",
                               rsp_own_q.size(), gnt_own_q.size());
        end
        m_key = 32'hDEAD_BEFF; m_lat = 2;
        c1 = cyc;
        bus.IF_ADDR = 32'h0000_0010; bus.IF_REQ = 1'b1;
        wait_rsp(1, 40);
        n_run++;
        if (rsp_own_q.size() !== 1 || rsp_own_q[0] !== 0 || rsp_cyc_q[0] !== c1 + 4 ||
            rsp_data_q[0] !== 32'hDEAD_BEEF || rsp_err_q[0] !== 1'b0) begin
            n_fail++; $display("FAIL rstw_after: got n=%0d own=%0d cyc=%0d data=%h, expected IF cyc=%0d deadbeef",
                               rsp_own_q.size(), rsp_own_q[0], rsp_cyc_q[0], rsp_data_q[0], c1 + 4);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_store_ack();
        test_backpressure_timeout();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: instruction fetch (IF, read-only) and data access from the execute stage (DM, load/store).
- Sits between the CPU stage sequencer and the memory. It sequences each access as grant, then issue, then wait for response, then return.
- DM has priority. A streak limit prevents fetch starvation, and a timeout guarantees forward progress.

Parameters:
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF is pending before IF is forced to win.
- TIMEOUT_CYCLES, 16, WAIT-state cycles without MEM_RVALID before an error response is returned.

Ports:
- CLK  in  1  clock, rising edge
- RSTN  in  1  asynchronous active-low reset
- IF_REQ  in  1  fetch request; held with IF_ADDR until IF_GNT
- IF_ADDR  in  32  fetch address
- IF_GNT  out  1  one-cycle pulse: fetch accepted
- IF_RVALID  out  1  one-cycle pulse: fetch response
- IF_RDATA  out  32  fetch data
- DM_REQ  in  1  data request; held with fields until DM_GNT
- DM_WE  in  1  1 = store
- DM_ADDR  in  32  data address
- DM_WDATA  in  32  store data
- DM_BE  in  4  byte enables
- DM_GNT  out  1  one-cycle pulse: data request accepted
- DM_RVALID  out  1  one-cycle pulse: load data or store acknowledge
- DM_RDATA  out  32  load data
- RESP_ERR  out  1  qualifies the current IF_RVALID/DM_RVALID pulse as a timeout
- BUSY  out  1  state != IDLE
- MEM_REQ  out  1  memory request
- MEM_WE  out  1  memory write enable
- MEM_ADDR  out  32  memory address
- MEM_WDATA  out  32  memory write data
- MEM_BE  out  4  memory byte enables
- MEM_READY  in  1  memory accepts MEM_REQ this cycle
- MEM_RVALID  in  1  memory response, one per accepted request (reads and writes)
- MEM_RDATA  in  32  memory read data

Behaviour:
- Reset (asynchronous, RSTN=0):
  - state goes to IDLE; streak and timeout counters clear.
  - All outputs go to 0.
  - Any in-flight access is dropped and no response is produced for it.
- States: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE:
  - At a posedge where IF_REQ or DM_REQ is high, pick the owner.
  - Owner rule: DM wins, unless IF_REQ=1 and streak==MAX_DM_STREAK, in which case IF wins.
  - Latch the owner's addr/we/wdata/be. IF access is forced to we=0, be=4'hF.
  - Go to ISSUE. The owner's GNT is high for exactly the next cycle.
- ISSUE:
  - MEM_REQ=1 with the latched fields.
  - At a posedge with MEM_READY=1, go to WAIT, drop MEM_REQ and clear the timeout counter.
  - The state is held indefinitely while MEM_READY=0. No timeout applies in ISSUE.
- WAIT:
  - The timeout counter increments each cycle.
  - At a posedge with MEM_RVALID=1: the owner's RVALID pulses for one cycle. For a read, the owner's RDATA is loaded with MEM_RDATA. For a DM write, DM_RDATA holds its previous value. RESP_ERR=0. Go to IDLE.
  - If the counter reaches TIMEOUT_CYCLES first: the owner's RVALID pulses with RESP_ERR=1 and RDATA=0. Go to IDLE.
- MEM_RVALID is ignored outside WAIT. A late response after a timeout is discarded.
- Streak counter:
  - On a DM grant with IF_REQ=1: increment, saturating at MAX_DM_STREAK.
  - On a DM grant with IF_REQ=0: clear.
  - On an IF grant: clear.
- Latency:
  - REQ sampled at edge t, GNT and MEM_REQ high in cycle t+1.
  - With MEM_READY=1 and memory latency L (MEM_RVALID sampled at edge t+1+L), RVALID is high in cycle t+2+L.
  - The next grant is decided at that same edge, so a held request sees GNT in cycle t+3+L.
- Exactly one access is outstanding at a time. Requests arriving during ISSUE/WAIT wait with REQ held.
- RDATA outputs hold their value between responses.

Decomposition:
- Add to the shared def package:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT}.
  - arb_owner_t enum {OWNER_IF, OWNER_DM}.
  - mem_req_t packed struct {we, addr[31:0], wdata[31:0], be[3:0]}.
- One sub-module, arb_pick:
  - Contains the owner-selection logic and the streak counter (CLK/RSTN, IF_REQ, DM_REQ, grant strobe, owner out).
  - The top module holds the FSM, the request latch, the timeout counter and response routing.

Test Plan:
- Single fetch: IF_REQ, IF_ADDR=0x10; memory L=2 returns 0xDEADBEEF -> IF_GNT in cycle t+1, IF_RVALID and IF_RDATA=0xDEADBEEF in cycle t+4, RESP_ERR=0, BUSY low afterwards.
- Simultaneous IF and DM: both requesting, DM a load at 0x200 -> DM granted first, IF granted next, memory sees address 0x200 then IF_ADDR, each RVALID is routed to the correct side.
- Starvation guard: DM_REQ continuously high plus IF_REQ high, MAX_DM_STREAK=4 -> 4 DM grants, then an IF grant, then DM again.
- Store acknowledge: DM_WE=1, DM_ADDR=0x1FC, DM_WDATA=0x5, DM_BE=4'hF -> MEM_WE=1 with matching fields, DM_RVALID pulses, DM_RDATA unchanged.
- Backpressure and timeout: MEM_READY=0 for 10 cycles -> MEM_REQ held, no error. MEM_READY=1 with no MEM_RVALID -> after 16 cycles the owner gets RVALID with RESP_ERR=1 and RDATA=0; a late MEM_RVALID is ignored.
- Reset during WAIT: RSTN low mid-access -> all outputs 0 immediately, no RVALID for the dropped access, and a new request is served normally after release.
